dsram_arbiter: RTL and testbench

Arbitrates the single-port data SRAM between the CPU memory-access stage and a DMA/debug master. The CPU normally wins. A starvation counter forces a DMA slot after a bounded wait. Two-cycle misaligned CPU stores are never split by a DMA access. The block sits between the memory-access stage's dsram_* outputs and the physical data SRAM macro, and it steers 1-cycle-latency read data back to the correct requester.

---
 rtl/dsram_arbiter_if.sv | 57 +++++
 rtl/dsram_arbiter.sv | 119 +++++++++++
 tb/tb_dsram_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsram_arbiter_if.sv
// dsram_arbiter_if
// Bundles the three buses around the data-SRAM arbiter:
//   cpu_*   : memory-access stage request, stall and read-data return
//   dma_*   : DMA/debug master request, grant and read-data return
//   dsram_* : physical single-port SRAM macro (1-cycle read latency)
//   arb_state : debug view of the arbiter state (0 ARB, 1 LOCK)
// Modports:
//   slave  : the arbiter (consumes requests, drives grants and the SRAM)
//   master : the surrounding environment (requesters and SRAM macro)
interface dsram_arbiter_if;
  logic        cpu_cs;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_ben;
  logic [31:0] cpu_wdata;
  logic        cpu_lock;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [3:0]  dma_ben;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic        dsram_cs;
  logic        dsram_we;
  logic [31:0] dsram_addr;
  logic [3:0]  dsram_ben;
  logic [31:0] dsram_wdata;
  logic [31:0] dsram_rdata;

  logic [1:0]  arb_state;

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_ben, cpu_wdata, cpu_lock,
    input  dma_req, dma_we, dma_addr, dma_ben, dma_wdata,
    input  dsram_rdata,
    output cpu_stall, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dsram_cs, dsram_we, dsram_addr, dsram_ben, dsram_wdata,
    output arb_state
  );

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_ben, cpu_wdata, cpu_lock,
    output dma_req, dma_we, dma_addr, dma_ben, dma_wdata,
    output dsram_rdata,
    input  cpu_stall, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dsram_cs, dsram_we, dsram_addr, dsram_ben, dsram_wdata,
    input  arb_state
  );
endinterface

// File: rtl/dsram_arbiter.sv
// dsram_arbiter
// Shares the single-port data SRAM between the CPU memory-access stage and a
// DMA/debug master. The CPU normally owns the SRAM; a saturating starvation
// counter forces one DMA slot after STARVE_LIMIT consecutive ungranted DMA
// request cycles. The first half of a misaligned CPU store (cpu_lock) moves
// the arbiter to LOCK so the second half cannot be split by a DMA access.
// Grant and SRAM mux are combinational (same-cycle); DMA read data is steered
// back one cycle after the grant.
// Ports:
//   clk      : core clock, rising edge
//   cpurst_n : asynchronous active-low reset
//   bus      : dsram_arbiter_if.slave (cpu_*, dma_*, dsram_*, arb_state)
// Parameter:
//   STARVE_LIMIT : ungranted DMA cycles before DMA is forced (1..15)
module dsram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           cpurst_n,
  dsram_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_LOCK = 2'd1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  state_t     state_q;
  state_t     state_d;
  owner_t     owner;
  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       rd_dma_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == LIMIT) ? v : v + 4'd1;
  endfunction

  // Stage p0: owner selection, next state, SRAM mux (all combinational)
  always_comb begin
    owner   = OWN_NONE;
    state_d = ST_ARB;
    case (state_q)
      ST_LOCK: owner = OWN_CPU;
      default: begin
        if (bus.dma_req && (!bus.cpu_cs || starve_cnt_q == LIMIT))
          owner = OWN_DMA;
        else if (bus.cpu_cs)
          owner = OWN_CPU;
      end
    endcase
    // LOCK lasts exactly one cycle; cpu_lock seen in LOCK is ignored.
    if (state_q == ST_ARB && owner == OWN_CPU && bus.cpu_lock)
      state_d = ST_LOCK;
  end

  always_comb begin
    starve_cnt_d = sat_inc(starve_cnt_q);
    if (owner == OWN_DMA || !bus.dma_req)
      starve_cnt_d = 4'd0;
  end

  always_comb begin
    bus.dsram_cs    = 1'b0;
    bus.dsram_we    = 1'b0;
    bus.dsram_addr  = 32'd0;
    bus.dsram_ben   = 4'd0;
    bus.dsram_wdata = 32'd0;
    case (owner)
      OWN_CPU: begin
        bus.dsram_cs    = bus.cpu_cs;
        bus.dsram_we    = bus.cpu_we;
        bus.dsram_addr  = bus.cpu_addr;
        bus.dsram_ben   = bus.cpu_ben;
        bus.dsram_wdata = bus.cpu_wdata;
      end
      OWN_DMA: begin
        bus.dsram_cs    = 1'b1;
        bus.dsram_we    = bus.dma_we;
        bus.dsram_addr  = bus.dma_addr;
        bus.dsram_ben   = bus.dma_ben;
        bus.dsram_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign bus.dma_gnt   = (owner == OWN_DMA);
  assign bus.cpu_stall = bus.cpu_cs && (owner != OWN_CPU);
  assign bus.arb_state = state_q;

  // Stage p1: state, starvation counter and DMA read-return flag
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q      <= ST_ARB;
      starve_cnt_q <= 4'd0;
      rd_dma_p1    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_dma_p1    <= (owner == OWN_DMA) && !bus.dma_we;
    end
  end

  // SRAM read data arrives one cycle after the grant; the CPU always sees it,
  // the DMA master only when the previous cycle was its read.
  assign bus.cpu_rdata  = bus.dsram_rdata;
  assign bus.dma_rvalid = rd_dma_p1;
  assign bus.dma_rdata  = rd_dma_p1 ? bus.dsram_rdata : 32'd0;

endmodule

// File: tb/tb_dsram_arbiter.sv
module tb_dsram_arbiter;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic cpurst_n;
  always #5 clk = ~clk;

  dsram_arbiter_if bus();

  dsram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .cpurst_n (cpurst_n),
    .bus      (bus)
  );

  // Behavioural SRAM macro: byte-enabled writes, 1-cycle registered reads.
  logic [31:0] sram [64] = '{default: 32'd0};
  always @(posedge clk) begin
    if (bus.dsram_cs) begin
      if (bus.dsram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.dsram_ben[b])
            sram[bus.dsram_addr[7:2]][8*b +: 8] <= bus.dsram_wdata[8*b +: 8];
      end else begin
        bus.dsram_rdata <= sram[bus.dsram_addr[7:2]];
      end
    end
  end

  typedef struct {
    logic        gnt, stall, cs, we;
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] wd;
    logic [1:0]  st;
    logic        rv;
    logic [31:0] rd;
    logic        cpu_chk;
    logic [31:0] crd;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mem_ref [64] = '{default: 32'd0};
  int          m_wait = 0;
  bit          m_lock = 0;
  bit          m_prev_dma_rd = 0, m_prev_cpu_rd = 0;
  logic [31:0] m_prev_val = 32'd0;
  bit          m_pw = 0;
  int          m_pw_idx = 0;
  logic [3:0]  m_pw_ben = 4'd0;
  logic [31:0] m_pw_data = 32'd0;
  bit          m_last_stall = 0, m_last_dma_wait = 0;

  // Last presented request fields (so held requests can be re-presented)
  logic        lc_cs = 0, lc_we = 0, lc_lock = 0;
  logic [31:0] lc_addr = 0, lc_wd = 0;
  logic [3:0]  lc_ben = 0;
  logic        ld_req = 0, ld_we = 0;
  logic [31:0] ld_addr = 0, ld_wd = 0;
  logic [3:0]  ld_ben = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      check("dma_gnt",     32'(bus.dma_gnt),    32'(me.gnt));
      check("cpu_stall",   32'(bus.cpu_stall),  32'(me.stall));
      check("dsram_cs",    32'(bus.dsram_cs),   32'(me.cs));
      check("dsram_we",    32'(bus.dsram_we),   32'(me.we));
      check("dsram_addr",  bus.dsram_addr,      me.addr);
      check("dsram_ben",   32'(bus.dsram_ben),  32'(me.ben));
      check("dsram_wdata", bus.dsram_wdata,     me.wd);
      check("arb_state",   32'(bus.arb_state),  32'(me.st));
      check("dma_rvalid",  32'(bus.dma_rvalid), 32'(me.rv));
      check("dma_rdata",   bus.dma_rdata,       me.rd);
      if (me.cpu_chk) check("cpu_rdata", bus.cpu_rdata, me.crd);
    end
  end

  // One clock cycle of stimulus; the model predicts this cycle's outputs.
  task automatic drive(input logic c_cs, input logic c_we, input logic [31:0] c_addr,
                       input logic [3:0] c_ben, input logic [31:0] c_wd, input logic c_lock,
                       input logic d_req, input logic d_we, input logic [31:0] d_addr,
                       input logic [3:0] d_ben, input logic [31:0] d_wd);
    exp_t e;
    int   own;
    int   idx;
    @(posedge clk);
    #1;
    if (m_pw) begin
      for (int b = 0; b < 4; b++)
        if (m_pw_ben[b]) mem_ref[m_pw_idx][8*b +: 8] = m_pw_data[8*b +: 8];
      m_pw = 0;
    end
    bus.cpu_cs = c_cs; bus.cpu_we = c_we; bus.cpu_addr = c_addr;
    bus.cpu_ben = c_ben; bus.cpu_wdata = c_wd; bus.cpu_lock = c_lock;
    bus.dma_req = d_req; bus.dma_we = d_we; bus.dma_addr = d_addr;
    bus.dma_ben = d_ben; bus.dma_wdata = d_wd;
    lc_cs = c_cs; lc_we = c_we; lc_addr = c_addr; lc_ben = c_ben; lc_wd = c_wd; lc_lock = c_lock;
    ld_req = d_req; ld_we = d_we; ld_addr = d_addr; ld_ben = d_ben; ld_wd = d_wd;

    // 0 none, 1 CPU, 2 DMA
    if (m_lock) own = 1;
    else if (d_req && (!c_cs || m_wait >= LIMIT)) own = 2;
    else if (c_cs) own = 1;
    else own = 0;

    e.gnt = (own == 2);
    e.stall = c_cs && (own != 1);
    e.cs = 0; e.we = 0; e.addr = 0; e.ben = 0; e.wd = 0;
    if (own == 1) begin
      e.cs = c_cs; e.we = c_we; e.addr = c_addr; e.ben = c_ben; e.wd = c_wd;
    end else if (own == 2) begin
      e.cs = 1; e.we = d_we; e.addr = d_addr; e.ben = d_ben; e.wd = d_wd;
    end
    e.st = m_lock ? 2'd1 : 2'd0;
    e.rv = m_prev_dma_rd;
    e.rd = m_prev_dma_rd ? m_prev_val : 32'd0;
    e.cpu_chk = m_prev_cpu_rd;
    e.crd = m_prev_val;
    exp_q.push_back(e);

    // Effects of the edge that closes this cycle
    idx = int'(e.addr[7:2]);
    m_prev_dma_rd = (own == 2) && !d_we;
    m_prev_cpu_rd = (own == 1) && c_cs && !c_we;
    if (e.cs && !e.we) m_prev_val = mem_ref[idx];
    if (e.cs && e.we) begin
      m_pw = 1; m_pw_idx = idx; m_pw_ben = e.ben; m_pw_data = e.wd;
    end
    if (own == 2 || !d_req) m_wait = 0;
    else if (m_wait < LIMIT) m_wait = m_wait + 1;
    m_lock = !m_lock && (own == 1) && c_lock;
    m_last_stall = e.stall;
    m_last_dma_wait = d_req && (own != 2);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dma_op(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    drive(0, 0, 0, 0, 0, 0, 1, we, a, be, wd);
  endtask

  task automatic contend(input int n);
    for (int i = 0; i < n; i++)
      drive(1, 0, 32'h80, 4'hF, 0, 0, 1, 0, 32'h84, 4'hF, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without a clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_lock = 0; bus.dma_req = 0; bus.dma_we = 0;
    cpurst_n = 0;
    #1;
    check("rst_arb_state",  32'(bus.arb_state),  32'd0);
    check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("rst_dma_rdata",  bus.dma_rdata,       32'd0);
    check("rst_dsram_cs",   32'(bus.dsram_cs),   32'd0);
    m_lock = 0; m_wait = 0; m_prev_dma_rd = 0; m_prev_cpu_rd = 0; m_pw = 0;
    m_last_stall = 0; m_last_dma_wait = 0;
    @(negedge clk);
    cpurst_n = 1;
  endtask

  task automatic rand_cycle();
    logic        c_cs, c_we, c_lock, d_req, d_we;
    logic [31:0] c_addr, c_wd, d_addr, d_wd;
    logic [3:0]  c_ben, d_ben;
    if (m_lock) begin
      c_cs = 1; c_we = 1; c_lock = 0;
      c_addr = {24'd0, 6'(lc_addr[7:2] + 6'd1), 2'b00};
      c_ben = 4'($urandom_range(1, 15)); c_wd = $urandom;
    end else if (m_last_stall) begin
      c_cs = lc_cs; c_we = lc_we; c_lock = lc_lock; c_addr = lc_addr; c_ben = lc_ben; c_wd = lc_wd;
    end else begin
      c_cs = ($urandom_range(0, 3) != 0);
      c_we = 1'($urandom_range(0, 1));
      c_addr = {24'd0, 6'($urandom), 2'b00};
      c_ben = c_we ? 4'($urandom_range(1, 15)) : 4'hF;
      c_wd = $urandom;
      c_lock = c_cs && c_we && ($urandom_range(0, 3) == 0);
    end
    if (m_last_dma_wait) begin
      d_req = ld_req; d_we = ld_we; d_addr = ld_addr; d_ben = ld_ben; d_wd = ld_wd;
    end else begin
      d_req = 1'($urandom_range(0, 1));
      d_we = 1'($urandom_range(0, 1));
      d_addr = {24'd0, 6'($urandom), 2'b00};
      d_ben = d_we ? 4'($urandom_range(1, 15)) : 4'hF;
      d_wd = $urandom;
    end
    drive(c_cs, c_we, c_addr, c_ben, c_wd, c_lock, d_req, d_we, d_addr, d_ben, d_wd);
  endtask

  initial begin
    cpurst_n = 0;
    bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_ben = 0;
    bus.cpu_wdata = 0; bus.cpu_lock = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_ben = 0; bus.dma_wdata = 0;
    #12;
    check("init_arb_state",  32'(bus.arb_state),  32'd0);
    check("init_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("init_dma_gnt",    32'(bus.dma_gnt),    32'd0);
    check("init_dsram_cs",   32'(bus.dsram_cs),   32'd0);
    check("init_dsram_addr", bus.dsram_addr,      32'd0);
    @(negedge clk);
    cpurst_n = 1;

    // DMA write then single DMA read of 0x40
    dma_op(1, 32'h40, 4'hF, 32'hDEADBEEF);
    dma_op(0, 32'h40, 4'hF, 32'd0);
    idle();
    idle();
    // DMA partial write, no read return follows
    dma_op(1, 32'h10, 4'b0110, 32'h00ABCD00);
    idle();
    // Back-to-back DMA reads
    dma_op(0, 32'h0, 4'hF, 0);
    dma_op(0, 32'h4, 4'hF, 0);
    idle();
    idle();
    // Continuous contention: forced DMA slot after LIMIT CPU cycles
    contend(LIMIT + 3);
    idle();
    // Lock issued just as the counter saturates: DMA deferred past LOCK
    contend(LIMIT - 1);
    drive(1, 1, 32'h20, 4'hF, 32'h11223344, 1, 1, 0, 32'h84, 4'hF, 0);
    drive(1, 1, 32'h24, 4'h3, 32'h55667788, 0, 1, 0, 32'h84, 4'hF, 0);
    drive(1, 0, 32'h20, 4'hF, 0, 0, 1, 0, 32'h84, 4'hF, 0);
    drive(1, 0, 32'h20, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Reset during LOCK abandons the second store half
    drive(1, 1, 32'h30, 4'hF, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h34, 4'hF, 32'hBAADF00D, 0, 0, 0, 0, 0, 0);
    pulse_reset();
    drive(1, 0, 32'h34, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Reset while a DMA read return is pending
    dma_op(0, 32'h40, 4'hF, 0);
    idle();
    pulse_reset();
    // Reset clears a saturated starvation counter
    contend(LIMIT + 1);
    pulse_reset();
    contend(LIMIT + 2);
    idle();
    // Randomized traffic
    for (int i = 0; i < 3000; i++) rand_cycle();
    idle();
    idle();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
